// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
// --------------
// Direction scheduler between the keycode decoder and the snake movement
// logic. Legal one-hot turn requests are buffered in a small FIFO. Exactly
// one queued turn is applied per qualifying game step, so fast key sequences
// land on consecutive steps instead of being lost.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   key_valid    in   one-cycle strobe, movement holds a decoded direction
//   movement     in   one-hot direction (0001 up, 0010 left, 0100 down, 1000 right)
//   tick         in   one-cycle game-step strobe
//   enable       in   game running; gates tick only
//   clear        in   synchronous new-game flush, highest priority
//   dir          out  current one-hot heading
//   step         out  one-cycle pulse, advance one cell toward dir
//   queue_count  out  number of pending turns
//   queue_full   out  queue_count == DEPTH
//   drop_cnt     out  rejected requests, saturating at 255
//
// Strobe semantics: key_valid and tick are single-cycle strobes with no
// back-pressure. A request is sampled on the edge where key_valid is high
// and is either queued or discarded on that same edge. A tick is sampled
// on its edge and produces step one cycle later, together with the new dir.

module snake_dir_ctrl #(
    parameter int         DEPTH     = 4,
    parameter logic [3:0] RESET_DIR = 4'b1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     key_valid,
    input  logic [3:0]               movement,
    input  logic                     tick,
    input  logic                     enable,
    input  logic                     clear,
    output logic [3:0]               dir,
    output logic                     step,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     queue_full,
    output logic [7:0]               drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]    fifo_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          full_d;
    logic [3:0]    dir_q;
    logic          step_q;
    logic [7:0]    drop_q;

    logic [3:0]    ref_dir;
    logic [3:0]    opp_dir;
    logic          is_onehot;
    logic          is_dup;
    logic          is_rev;
    logic          push;
    logic          pop;
    logic          drop;

    always_comb begin
        // Reference is the newest pending turn, so filtering is against the
        // heading the snake will have when this request is finally applied.
        ref_dir   = (count_q != '0) ? fifo_q[wr_ptr_q - PW'(1)] : dir_q;
        opp_dir   = {ref_dir[1:0], ref_dir[3:2]};
        is_onehot = (movement == 4'b0001) || (movement == 4'b0010) ||
                    (movement == 4'b0100) || (movement == 4'b1000);
        is_dup    = is_onehot && (movement == ref_dir);
        is_rev    = is_onehot && (movement == opp_dir);

        // Full uses the pre-edge count: a same-cycle pop does not make room.
        push = key_valid && is_onehot && !is_dup && !is_rev && !full_q;
        drop = key_valid && (!is_onehot || (!is_dup && (is_rev || full_q)));
        pop  = tick && enable && (count_q != '0);

        count_d = count_q + CW'(push) - CW'(pop);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            dir_q    <= RESET_DIR;
            step_q   <= 1'b0;
            drop_q   <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            dir_q    <= RESET_DIR;
            step_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            step_q <= tick && enable;
            if (pop) begin
                dir_q    <= fifo_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= movement;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            count_q <= count_d;
            full_q  <= full_d;
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign dir         = dir_q;
    assign step        = step_q;
    assign queue_count = count_q;
    assign queue_full  = full_q;
    assign drop_cnt    = drop_q;

endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Direction scheduler between the keyboard keycode decoder and the snake movement logic. Buffers one-hot direction requests in a small FIFO and filters out illegal turns (reversal, duplicate, malformed). Applies exactly one queued turn per game step, so fast key sequences land on consecutive steps instead of being lost or overwritten. Emits the current heading plus a step strobe that the body/position logic consumes.

## Interface

Parameters:
- `DEPTH`, default 4: turn-queue depth. Power of two, ≥2.
- `RESET_DIR`, default 4'b1000: heading after reset or clear (right).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `key_valid`  in  1  one-cycle strobe; `movement` holds a new decoded direction.
- `movement`  in  4  one-hot direction code:
  - 0001 up
  - 0010 left
  - 0100 down
  - 1000 right
- `tick`  in  1  one-cycle game-step strobe from the step timer.
- `enable`  in  1  game running. When 0, `tick` is ignored; the queue and key acceptance stay active.
- `clear`  in  1  synchronous new-game flush; highest priority.
- `dir`  out  4  current one-hot heading.
- `step`  out  1  one-cycle pulse; the snake advances one cell in direction `dir`.
- `queue_count`  out  $clog2(DEPTH)+1  number of pending turns.
- `queue_full`  out  1  `queue_count == DEPTH`.
- `drop_cnt`  out  8  number of rejected requests; saturates at 255.

## Operation

- **Reference heading `ref`:** the last enqueued entry (tail) if `queue_count > 0`, else `dir`. All values are pre-edge state.
- **Opposite of m:** `{m[1:0], m[3:2]}`, i.e. up↔down and left↔right.
- **On `key_valid`, classify the request:**
  - **Invalid:** `movement` is not exactly one-hot. Drop and increment `drop_cnt`.
  - **Duplicate:** `movement == ref`. Ignore silently; `drop_cnt` unchanged.
  - **Reversal:** `movement == opposite(ref)`. Drop and increment `drop_cnt`.
  - **Full:** pre-edge `queue_count == DEPTH`. Drop and increment `drop_cnt`, even when a pop happens in the same cycle.
  - **Otherwise:** push to the tail.
- **On `tick && enable`:**
  - If the queue is non-empty, pop the head into `dir`.
  - `step` = 1 on the next cycle whether or not a pop occurred.
- **Simultaneous push and pop:** both take effect; `queue_count` is unchanged.
- **Pointers:** `$clog2(DEPTH)`-bit read/write pointers that wrap modulo DEPTH. The count is kept separately so that full and empty are unambiguous.
- **`drop_cnt`:** saturates at 255; it never wraps.
- **`clear`:** on the next edge, `dir` = RESET_DIR, queue emptied (pointers and count 0), `drop_cnt` = 0, `step` = 0. Any `key_valid` or `tick` in the same cycle is discarded.
- **Reset values (`rst_n` low):** `dir` = RESET_DIR, `step` = 0, `queue_count` = 0, `queue_full` = 0, `drop_cnt` = 0, pointers = 0.
  - Asserting `rst_n` mid-operation discards all queued turns immediately, without waiting for a clock edge.

## Timing

- All outputs are registered.
- `step` and the new `dir` appear together, one cycle after the `tick` cycle. `dir` is stable while `step` is high.
- A key accepted at edge N is visible in `queue_count` after edge N.
- A key accepted with an empty queue reaches `dir` with the first qualifying `tick` sampled at or after edge N+1.
  - A `tick` in the same cycle as that `key_valid` does not apply the new key (pop decisions use pre-edge state).
- `queue_full` is registered together with `queue_count`.
- `tick` closer together than 2 cycles is legal; each qualifying tick produces one `step` and at most one pop.

## Test plan

- **Reset:** assert `rst_n` = 0 mid-run with 2 entries queued.
  - Required: immediately `dir` = 1000, `queue_count` = 0, `drop_cnt` = 0, `step` = 0.
- **Basic turn:** from reset, `key_valid` with `movement` = 0001, then `tick` 3 cycles later.
  - Required: `queue_count` = 1 after the key.
  - Required: one cycle after the tick, `step` = 1, `dir` = 0001, `queue_count` = 0.
- **Reversal and invalid filtering:** with `dir` = 1000, send 0010 (reversal), 1000 (duplicate), then 0011 (invalid).
  - Required: queue stays empty, `drop_cnt` = 2.
  - Then send 0001 followed by 0100: the second is a reversal of the tail, so it is dropped; `queue_count` = 1, `drop_cnt` = 3.
- **Buffered sequence:** from `dir` = 1000, send 0001 then 0010 between ticks, then issue two ticks.
  - Required: `dir` = 0001 after tick 1 and 0010 after tick 2; each tick produces one `step` pulse.
- **Overflow:** DEPTH = 4; enqueue the alternating legal sequence 0001, 0010, 0100, 1000, then send a 5th legal key (0001) in the same cycle as a tick.
  - Required: the 5th key is dropped (`drop_cnt` +1) and the pop occurs, so `queue_count` = 3.
  - Drive 300 further rejected keys: `drop_cnt` holds at 255.
- **Enable and clear:** with `enable` = 0 and 2 entries queued, pulse `tick`.
  - Required: no `step`, `dir` unchanged, `queue_count` = 2.
  - Then assert `clear` together with `tick` and `key_valid`: next cycle `dir` = 1000, `queue_count` = 0, `step` = 0.
